// File: rtl/vdma_pkg.sv
// Shared types for the VDMA write-side scheduler.
//   wr_state_e : scheduler FSM states
//   wr_req_t   : burst request {byte address, pixel count}
//   IDX_W      : width of frame-buffer index ports
package vdma_pkg;

  localparam int IDX_W  = 3;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_DRAIN
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } wr_req_t;

endpackage

// File: rtl/vdma_req_fifo.sv
// Synchronous FIFO of burst requests.
//   clock, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   push_i/data_i: write one request (ignored when full)
//   pop_i        : consume the head (ignored when empty)
//   full_o/empty_o: occupancy flags
//   head_o       : head entry, forced to zero while empty
// DEPTH must be a power of two so the pointers wrap naturally.
module vdma_req_fifo
  import vdma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clock,
  input  logic    rst_n,
  input  logic    push_i,
  input  wr_req_t data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wr_req_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vdma_wr_scheduler.sv
// VDMA write-side scheduler: counts input pixels against falign/lalign/ealign,
// rotates through FRAME_NUM frame buffers and queues burst requests for the
// AXI write master.
//   clock, rst_n        : clock, synchronous active-low reset
//   enable              : capture from next falign; drop to stop after frame
//   fb_base/frame_bytes : buffer 0 address and buffer spacing
//   stride, rd_index    : line pitch, buffer owned by the reader
//   falign/lalign/ealign/din_vld : video timing and pixel valid
//   req_valid/req_ready/req_addr/req_len : request handshake to write master
//   burst_done          : one burst completed by the write master
//   wr_index, frame_done, ovf_err, frame_err : status
// Build option: define VDMA_WR_SKIP_RD_BUF_EN to skip the buffer named by
// rd_index during the second ARM cycle (needs FRAME_NUM >= 3).
module vdma_wr_scheduler
  import vdma_pkg::*;
#(
  parameter int BURST_LEN = 64,
  parameter int BPP       = 4,
  parameter int FRAME_NUM = 3,
  parameter int REQ_DEPTH = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [31:0]       fb_base,
  input  logic [31:0]       frame_bytes,
  input  logic [15:0]       stride,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic              falign,
  input  logic              lalign,
  input  logic              ealign,
  input  logic              din_vld,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [31:0]       req_addr,
  output logic [8:0]        req_len,
  input  logic              burst_done,
  output logic [IDX_W-1:0]  wr_index,
  output logic              frame_done,
  output logic              ovf_err,
  output logic              frame_err
);

  localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * BPP);
  localparam logic [8:0]       BURST_LEN_L = 9'(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_NUM - 1);
  localparam int               OUT_W       = $clog2(REQ_DEPTH) + 2;

  wr_state_e        state_q, state_d;
  logic             arm2_q, arm2_d;
  logic [IDX_W-1:0] wr_index_q, wr_index_d;
  logic [31:0]      frame_base_q, frame_base_d;
  logic [31:0]      line_addr_q, line_addr_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [8:0]       pix_cnt_q, pix_cnt_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             fpend_q, fpend_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_q;

  logic             push;
  wr_req_t          push_req, head;
  logic             q_full, q_empty;
  logic             drain_ok, take;
  logic [IDX_W-1:0] adv_idx;
  logic [31:0]      adv_base;

  vdma_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (req_ready),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  assign req_valid  = !q_empty;
  assign req_addr   = head.addr;
  assign req_len    = head.len;
  assign wr_index   = wr_index_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign ovf_err    = ovf_q;

  assign take     = req_valid && req_ready;
  assign drain_ok = q_empty && (outstanding_q == '0);

  // One step around the ring; base returns to fb_base when the index wraps.
  assign adv_idx  = (wr_index_q == LAST_IDX) ? '0 : wr_index_q + 1'b1;
  assign adv_base = (wr_index_q == LAST_IDX) ? fb_base : frame_base_q + frame_bytes;

`ifndef VDMA_WR_SKIP_RD_BUF_EN
  logic unused_rd_index;
  assign unused_rd_index = ^rd_index;
`endif

  // State and control registers
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      arm2_q        <= 1'b0;
      wr_index_q    <= LAST_IDX;
      outstanding_q <= '0;
      fpend_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm2_q        <= arm2_d;
      wr_index_q    <= wr_index_d;
      outstanding_q <= outstanding_d;
      fpend_q       <= fpend_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      if (push && q_full) ovf_q <= 1'b1;
    end
  end

  // Address/count registers are always (re)loaded in ARM before use.
  always_ff @(posedge clock) begin
    frame_base_q <= frame_base_d;
    line_addr_q  <= line_addr_d;
    cur_addr_q   <= cur_addr_d;
    pix_cnt_q    <= pix_cnt_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    arm2_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (falign && enable) state_d = ST_ARM;
      ST_ARM:    if (arm2_q) state_d = ST_ACTIVE; else arm2_d = 1'b1;
      ST_ACTIVE: begin
        if (falign)      state_d = ST_ARM;
        else if (ealign) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (drain_ok) state_d = ((fpend_q || falign) && enable) ? ST_ARM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    push          = 1'b0;
    push_req.addr = cur_addr_q;
    push_req.len  = pix_cnt_q;
    wr_index_d    = wr_index_q;
    frame_base_d  = frame_base_q;
    line_addr_d   = line_addr_q;
    cur_addr_d    = cur_addr_q;
    pix_cnt_d     = pix_cnt_q;
    fpend_d       = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    unique case (state_q)
      ST_ARM: begin
        if (!arm2_q) begin
          wr_index_d   = adv_idx;
          frame_base_d = adv_base;
        end else begin
`ifdef VDMA_WR_SKIP_RD_BUF_EN
          if (wr_index_q == rd_index) begin
            wr_index_d   = adv_idx;
            frame_base_d = adv_base;
          end
`endif
          line_addr_d = frame_base_d;
          cur_addr_d  = frame_base_d;
          pix_cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (falign) begin
          frame_err_d = 1'b1;
          pix_cnt_d   = '0;
        end else if (lalign) begin
          // A pixel arriving with lalign starts the next line.
          push        = (pix_cnt_q != '0);
          line_addr_d = line_addr_q + {16'h0, stride};
          cur_addr_d  = line_addr_d;
          pix_cnt_d   = din_vld ? 9'd1 : 9'd0;
        end else if (din_vld) begin
          if (pix_cnt_q == BURST_LEN_L - 9'd1) begin
            push         = 1'b1;
            push_req.len = BURST_LEN_L;
            cur_addr_d   = cur_addr_q + BURST_BYTES;
            pix_cnt_d    = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        fpend_d = fpend_q || falign;
        if (drain_ok) begin
          frame_done_d = 1'b1;
          fpend_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Bursts in flight; a burst_done with nothing outstanding is ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({take, burst_done})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

endmodule
